// File: rtl/apb_i2c_regif_pkg.sv
// Shared definitions for the APB register front end of the I2C core:
// register offsets, interrupt bit positions and the transfer FSM states.
package apb_i2c_pkg;

    localparam logic [7:0] REG_TXDATA     = 8'h00;
    localparam logic [7:0] REG_RXDATA     = 8'h04;
    localparam logic [7:0] REG_CONFIG     = 8'h08;
    localparam logic [7:0] REG_TIMEOUT    = 8'h0C;
    localparam logic [7:0] REG_INT_STATUS = 8'h10;
    localparam logic [7:0] REG_INT_ENABLE = 8'h14;
    localparam logic [7:0] REG_STATUS     = 8'h18;

    // Word indices used by the decoder (byte offset with bits [1:0] dropped)
    localparam logic [2:0] IDX_TXDATA     = REG_TXDATA[4:2];
    localparam logic [2:0] IDX_RXDATA     = REG_RXDATA[4:2];
    localparam logic [2:0] IDX_CONFIG     = REG_CONFIG[4:2];
    localparam logic [2:0] IDX_TIMEOUT    = REG_TIMEOUT[4:2];
    localparam logic [2:0] IDX_INT_STATUS = REG_INT_STATUS[4:2];
    localparam logic [2:0] IDX_INT_ENABLE = REG_INT_ENABLE[4:2];
    localparam logic [2:0] IDX_STATUS     = REG_STATUS[4:2];

    localparam int INT_W   = 5;
    localparam int INT_TXE  = 0;
    localparam int INT_RXNE = 1;
    localparam int INT_ERR  = 2;
    localparam int INT_OVF  = 3;
    localparam int INT_UNF  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_i2c_irq_ctrl.sv
// Interrupt block: edge detection on FIFO/core status, sticky W1C status,
// enable register and a registered, masked interrupt line.
module apb_i2c_irq_ctrl
    import apb_i2c_pkg::*;
(
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             tx_empty,
    input  logic             rx_empty,
    input  logic             core_error,
    input  logic             ovf_set,
    input  logic             unf_set,
    input  logic [INT_W-1:0] w1c_mask,
    input  logic             ie_we,
    input  logic [INT_W-1:0] ie_wdata,
    output logic [INT_W-1:0] int_status,
    output logic [INT_W-1:0] int_enable,
    output logic             irq
);

    logic             tx_empty_q_r;
    logic             rx_empty_q_r;
    logic             err_q_r;
    logic [INT_W-1:0] status_r;
    logic [INT_W-1:0] enable_r;
    logic             irq_r;
    logic [INT_W-1:0] set_s;
    logic [INT_W-1:0] status_next_s;
    logic [INT_W-1:0] enable_next_s;

    // Next status/enable; sets are OR-ed after the clear so a coincident set wins
    always_comb begin
        set_s           = '0;
        set_s[INT_TXE]  = tx_empty & ~tx_empty_q_r;
        set_s[INT_RXNE] = ~rx_empty & rx_empty_q_r;
        set_s[INT_ERR]  = core_error & ~err_q_r;
        set_s[INT_OVF]  = ovf_set;
        set_s[INT_UNF]  = unf_set;
        status_next_s   = (status_r & ~w1c_mask) | set_s;
        if (ie_we) begin
            enable_next_s = ie_wdata;
        end else begin
            enable_next_s = enable_r;
        end
    end

    // Edge history, interrupt registers and the masked irq
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_empty_q_r <= 1'b1;
            rx_empty_q_r <= 1'b1;
            err_q_r      <= 1'b0;
            status_r     <= '0;
            enable_r     <= '0;
            irq_r        <= 1'b0;
        end else begin
            tx_empty_q_r <= tx_empty;
            rx_empty_q_r <= rx_empty;
            err_q_r      <= core_error;
            status_r     <= status_next_s;
            enable_r     <= enable_next_s;
            irq_r        <= |(status_next_s & enable_next_s);
        end
    end

    assign int_status = status_r;
    assign int_enable = enable_r;
    assign irq        = irq_r;

endmodule

// File: rtl/apb_i2c_regif.sv
// APB3 slave register interface for the I2C core: transfer FSM with wait
// states, address decode with PSLVERR, FIFO strobes and configuration registers.
module apb_i2c_regif
    import apb_i2c_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int CFG_W       = 14,
    parameter int TMO_W       = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              tx_wr_en,
    output logic [DATA_W-1:0] tx_wr_data,
    input  logic              tx_full,
    input  logic              tx_empty,
    output logic              rx_rd_en,
    input  logic [DATA_W-1:0] rx_rd_data,
    input  logic              rx_empty,
    input  logic              core_error,
    output logic [CFG_W-1:0]  cfg,
    output logic [TMO_W-1:0]  timeout,
    output logic              irq
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    apb_state_e        state_r;
    apb_state_e        state_next_s;
    logic [3:0]        wait_cnt_r;
    logic              req_write_r;
    logic [2:0]        req_idx_r;
    logic              req_bad_r;
    logic [CFG_W-1:0]  cfg_r;
    logic [TMO_W-1:0]  timeout_r;

    logic [ADDR_W-1:0] word_addr_s;
    logic              setup_s;
    logic              mapped_s;
    logic              bad_s;
    logic              wait_done_s;
    logic              complete_s;
    logic              is_tx_s;
    logic              is_rx_s;
    logic              fifo_err_s;
    logic              err_s;
    logic              ok_wr_s;
    logic              ok_rd_s;
    logic [DATA_W-1:0] rd_mux_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic [INT_W-1:0]  w1c_mask_s;
    logic              ie_we_s;
    logic [INT_W-1:0]  int_status_s;
    logic [INT_W-1:0]  int_enable_s;

    // Setup-phase decode; static errors depend only on address and direction
    always_comb begin
        setup_s     = PSEL & ~PENABLE;
        word_addr_s = PADDR >> 2;
        mapped_s    = (word_addr_s <= ADDR_W'(IDX_STATUS));
        bad_s       = ~mapped_s
                    | (PWRITE & ((word_addr_s[2:0] == IDX_RXDATA) | (word_addr_s[2:0] == IDX_STATUS)))
                    | (~PWRITE & (word_addr_s[2:0] == IDX_TXDATA));
        wait_done_s = (wait_cnt_r == WAIT_LAST);
    end

    // Transfer FSM next state; completion is suppressed while reset is asserted
    always_comb begin
        state_next_s = state_r;
        complete_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next_s = IDLE;
                end else if (!wait_done_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                    complete_s   = ~PRESET;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state, wait counter and latched request
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r     <= IDLE;
            wait_cnt_r  <= 4'd0;
            req_write_r <= 1'b0;
            req_idx_r   <= 3'd0;
            req_bad_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == IDLE) && setup_s) begin
                wait_cnt_r  <= 4'd0;
                req_write_r <= PWRITE;
                req_idx_r   <= word_addr_s[2:0];
                req_bad_r   <= bad_s;
            end else if ((state_r == ACCESS) && PSEL && !wait_done_s) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Completion-cycle results: FIFO-state errors, strobes and read mux
    always_comb begin
        is_tx_s    = (req_idx_r == IDX_TXDATA);
        is_rx_s    = (req_idx_r == IDX_RXDATA);
        fifo_err_s = ~req_bad_r & ((req_write_r & is_tx_s & tx_full)
                                 | (~req_write_r & is_rx_s & rx_empty));
        err_s      = req_bad_r | fifo_err_s;
        ok_wr_s    = complete_s & req_write_r & ~err_s;
        ok_rd_s    = complete_s & ~req_write_r & ~err_s;
        ovf_set_s  = complete_s & ~req_bad_r & req_write_r & is_tx_s & tx_full;
        unf_set_s  = complete_s & ~req_bad_r & ~req_write_r & is_rx_s & rx_empty;
        ie_we_s    = ok_wr_s & (req_idx_r == IDX_INT_ENABLE);
        if (ok_wr_s && (req_idx_r == IDX_INT_STATUS)) begin
            w1c_mask_s = PWDATA[INT_W-1:0];
        end else begin
            w1c_mask_s = '0;
        end
        case (req_idx_r)
            IDX_RXDATA:     rd_mux_s = rx_rd_data;
            IDX_CONFIG:     rd_mux_s = DATA_W'(cfg_r);
            IDX_TIMEOUT:    rd_mux_s = DATA_W'(timeout_r);
            IDX_INT_STATUS: rd_mux_s = DATA_W'(int_status_s);
            IDX_INT_ENABLE: rd_mux_s = DATA_W'(int_enable_s);
            IDX_STATUS:     rd_mux_s = DATA_W'({core_error, rx_empty, tx_full, tx_empty});
            default:        rd_mux_s = '0;
        endcase
    end

    // CONFIG and TIMEOUT registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cfg_r     <= '0;
            timeout_r <= '0;
        end else begin
            if (ok_wr_s && (req_idx_r == IDX_CONFIG)) begin
                cfg_r <= PWDATA[CFG_W-1:0];
            end else begin
                cfg_r <= cfg_r;
            end
            if (ok_wr_s && (req_idx_r == IDX_TIMEOUT)) begin
                timeout_r <= PWDATA[TMO_W-1:0];
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    apb_i2c_irq_ctrl u_irq (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .tx_empty   (tx_empty),
        .rx_empty   (rx_empty),
        .core_error (core_error),
        .ovf_set    (ovf_set_s),
        .unf_set    (unf_set_s),
        .w1c_mask   (w1c_mask_s),
        .ie_we      (ie_we_s),
        .ie_wdata   (PWDATA[INT_W-1:0]),
        .int_status (int_status_s),
        .int_enable (int_enable_s),
        .irq        (irq)
    );

    assign PREADY     = complete_s;
    assign PSLVERR    = complete_s & err_s;
    assign PRDATA     = ok_rd_s ? rd_mux_s : '0;
    assign tx_wr_en   = ok_wr_s & is_tx_s;
    assign tx_wr_data = PWDATA;
    assign rx_rd_en   = ok_rd_s & is_rx_s;
    assign cfg        = cfg_r;
    assign timeout    = timeout_r;

endmodule
